// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with optional even parity.
//
// The asynchronous rx line is synchronised, the start bit is confirmed at
// mid-bit, and data bits are shifted in LSB first, each sampled one bit
// period apart. A good stop bit loads the word and strobes valid; a low stop
// bit strobes frame_err and waits for the line to return high.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous active-high reset
//   rx         in   serial line, idle high, asynchronous to clk
//   data       out  last received word, updated only with valid
//   valid      out  one-cycle strobe: new word on data
//   parity_err out  parity mismatch, meaningful while valid is high
//   frame_err  out  one-cycle strobe: stop bit sampled low
//   busy       out  receiver is not idle
module uart_rx #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter bit          PARITY_EN    = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IdxW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [IdxW-1:0] IdxLast  = IdxW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } state_e;

    state_e                  state_q, state_d;
    logic                    rx_meta_q, rx_s_q;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    perr_q, perr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    parity_err_q, parity_err_d;
    logic                    frame_err_q, frame_err_d;
    logic                    busy_q, busy_d;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        perr_d       = perr_q;
        data_d       = data_q;
        valid_d      = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!rx_s_q) begin
                    state_d = StStart;
                    cnt_d   = '0;
                end
            end
            StStart: begin
                // Mid-bit check: a line already back high was only a glitch.
                if (cnt_q == HalfLast) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s_q ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StData: begin
                if (cnt_q == BitLast) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s_q;
                    idx_d          = idx_q + IdxW'(1);
                    if (idx_q == IdxLast) begin
                        state_d = PARITY_EN ? StParity : StStop;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StParity: begin
                if (cnt_q == BitLast) begin
                    cnt_d   = '0;
                    // Even parity: data plus parity bit must hold an even count of ones.
                    perr_d  = (^shift_q) ^ rx_s_q;
                    state_d = StStop;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StStop: begin
                if (cnt_q == BitLast) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        data_d       = shift_q;
                        valid_d      = 1'b1;
                        parity_err_d = PARITY_EN && perr_q;
                        state_d      = StIdle;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StBreak;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StBreak: begin
                // Wait out a held-low line so it is not mistaken for a start bit.
                if (rx_s_q) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            perr_q       <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            perr_q       <= perr_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomised frames against two receivers, one
// without parity (line rx0) and one with even parity (line rx1). Expected
// strobe times come from the frame arithmetic: a low level first sampled at
// clock edge P yields its valid/frame_err strobe at edge
// P + 2 + CPB/2 + (8 + parity + 1) * CPB.
module tb_uart_rx;

    localparam int DW  = 8;
    localparam int CPB = 16;
    localparam int H   = CPB / 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx0 = 1'b1;
    logic rx1 = 1'b1;

    logic [DW-1:0] data0, data1;
    logic valid0, valid1, perr0, perr1, ferr0, ferr1, busy0, busy1;

    uart_rx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx0),
        .data       (data0),
        .valid      (valid0),
        .parity_err (perr0),
        .frame_err  (ferr0),
        .busy       (busy0)
    );

    uart_rx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx1),
        .data       (data1),
        .valid      (valid1),
        .parity_err (perr1),
        .frame_err  (ferr1),
        .busy       (busy1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic [DW-1:0] d;
        logic          p;
    } ev_t;

    ev_t obs0[$], obs1[$], exp0[$], exp1[$];
    int  fobs0[$], fobs1[$], fexp0[$], fexp1[$];
    int  overlap = 0;
    logic [DW-1:0] last0 = '0;
    logic [DW-1:0] last1 = '0;

    int n_pass  = 0;
    int n_total = 0;

    // Monitor samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (valid0) obs0.push_back('{cyc, data0, perr0});
        if (valid1) obs1.push_back('{cyc, data1, perr1});
        if (ferr0) fobs0.push_back(cyc);
        if (ferr1) fobs1.push_back(cyc);
        if ((valid0 && ferr0) || (valid1 && ferr1)) overlap++;
    end

    initial begin
        #3_000_000;
        $fatal(1, "FAIL watchdog: simulation time limit reached");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drive one line level for n cycles; called and returns on a falling edge.
    task automatic hold(input int ln, input logic b, input int n);
        if (ln == 0) rx0 = b;
        else rx1 = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Sends one frame and records what the receiver on that line should report.
    task automatic send_frame(input int ln, input logic [DW-1:0] d, input logic pbit,
                              input logic stopb);
        int p;
        int pen;
        int done;
        p    = cyc + 1;
        pen  = (ln == 1) ? 1 : 0;
        done = p + 2 + H + (DW + pen + 1) * CPB;
        hold(ln, 1'b0, CPB);
        for (int i = 0; i < DW; i++) hold(ln, d[i], CPB);
        if (pen == 1) hold(ln, pbit, CPB);
        hold(ln, stopb, CPB);
        if (stopb) begin
            if (ln == 0) begin
                exp0.push_back('{done, d, 1'b0});
                last0 = d;
            end else begin
                exp1.push_back('{done, d, (^d) ^ pbit});
                last1 = d;
            end
        end else begin
            if (ln == 0) fexp0.push_back(done);
            else fexp1.push_back(done);
        end
    endtask

    task automatic compare_events(input string phase);
        chk({phase, " valid0 count"}, obs0.size(), exp0.size());
        for (int i = 0; i < exp0.size() && i < obs0.size(); i++) begin
            chk($sformatf("%s valid0[%0d] cycle", phase, i), obs0[i].cyc, exp0[i].cyc);
            chk($sformatf("%s data0[%0d]", phase, i), obs0[i].d, exp0[i].d);
            chk($sformatf("%s parity_err0[%0d]", phase, i), obs0[i].p, exp0[i].p);
        end
        chk({phase, " frame_err0 count"}, fobs0.size(), fexp0.size());
        for (int i = 0; i < fexp0.size() && i < fobs0.size(); i++)
            chk($sformatf("%s frame_err0[%0d] cycle", phase, i), fobs0[i], fexp0[i]);
        chk({phase, " valid1 count"}, obs1.size(), exp1.size());
        for (int i = 0; i < exp1.size() && i < obs1.size(); i++) begin
            chk($sformatf("%s valid1[%0d] cycle", phase, i), obs1[i].cyc, exp1[i].cyc);
            chk($sformatf("%s data1[%0d]", phase, i), obs1[i].d, exp1[i].d);
            chk($sformatf("%s parity_err1[%0d]", phase, i), obs1[i].p, exp1[i].p);
        end
        chk({phase, " frame_err1 count"}, fobs1.size(), fexp1.size());
        for (int i = 0; i < fexp1.size() && i < fobs1.size(); i++)
            chk($sformatf("%s frame_err1[%0d] cycle", phase, i), fobs1[i], fexp1[i]);
        obs0.delete(); obs1.delete(); exp0.delete(); exp1.delete();
        fobs0.delete(); fobs1.delete(); fexp0.delete(); fexp1.delete();
    endtask

    initial begin
        int p;
        logic [DW-1:0] rd;
        logic rp;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("reset data0", data0, 8'h00);
        chk("reset valid0", valid0, 1'b0);
        chk("reset parity_err0", perr0, 1'b0);
        chk("reset frame_err0", ferr0, 1'b0);
        chk("reset busy0", busy0, 1'b0);
        chk("reset data1", data1, 8'h00);
        chk("reset busy1", busy1, 1'b0);
        rst = 1'b0;
        hold(0, 1'b1, 10);

        // Single frame, exact strobe timing.
        send_frame(0, 8'hA5, 1'b0, 1'b1);
        hold(0, 1'b1, 10);
        compare_events("single");

        // Back-to-back frames with no idle gap.
        send_frame(0, 8'h00, 1'b0, 1'b1);
        send_frame(0, 8'hFF, 1'b0, 1'b1);
        send_frame(0, 8'h3C, 1'b0, 1'b1);
        hold(0, 1'b1, 10);
        compare_events("b2b");

        // Start glitch: 5 low cycles must be rejected at mid-bit.
        p = cyc + 1;
        hold(0, 1'b0, 5);
        rx0 = 1'b1;
        wait_cyc(p + 5);
        chk("glitch busy high", busy0, 1'b1);
        wait_cyc(p + 2 + H);
        chk("glitch busy dropped", busy0, 1'b0);
        hold(0, 1'b1, 200);
        compare_events("glitch");

        // Framing error, line held low, then recovery.
        send_frame(0, 8'h55, 1'b0, 1'b0);
        chk("frame_err data unchanged", data0, last0);
        hold(0, 1'b0, 25);
        chk("busy in break", busy0, 1'b1);
        hold(0, 1'b0, 25);
        hold(0, 1'b1, 20);
        chk("idle after break", busy0, 1'b0);
        send_frame(0, 8'h12, 1'b0, 1'b1);
        hold(0, 1'b1, 10);
        compare_events("break");

        // Even parity: 0x07 has three ones, so parity bit 1 is correct.
        send_frame(1, 8'h07, 1'b1, 1'b1);
        hold(1, 1'b1, 10);
        send_frame(1, 8'h07, 1'b0, 1'b1);
        hold(1, 1'b1, 10);
        compare_events("parity");

        // Reset in the middle of data bit 3 of 0x81.
        hold(0, 1'b0, CPB);
        for (int i = 0; i < 3; i++) hold(0, 1'(8'h81 >> i), CPB);
        hold(0, 1'b0, 7);
        chk("busy mid frame", busy0, 1'b1);
        #2;
        rst = 1'b1;
        rx0 = 1'b1;
        #1;
        chk("midreset data0", data0, 8'h00);
        chk("midreset valid0", valid0, 1'b0);
        chk("midreset parity_err0", perr0, 1'b0);
        chk("midreset frame_err0", ferr0, 1'b0);
        chk("midreset busy0", busy0, 1'b0);
        chk("midreset data1", data1, 8'h00);
        last0 = '0;
        last1 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        hold(0, 1'b1, 20);
        send_frame(0, 8'h42, 1'b0, 1'b1);
        hold(0, 1'b1, 10);
        compare_events("midreset");

        // Randomised frames with random short gaps on both receivers.
        for (int k = 0; k < 6; k++) begin
            rd = 8'($urandom);
            send_frame(0, rd, 1'b0, 1'b1);
            hold(0, 1'b1, $urandom_range(0, 3));
        end
        for (int k = 0; k < 6; k++) begin
            rd = 8'($urandom);
            rp = 1'($urandom);
            send_frame(1, rd, rp, 1'b1);
            hold(1, 1'b1, $urandom_range(0, 3));
        end
        hold(0, 1'b1, 10);
        compare_events("random");
        chk("final data0", data0, last0);
        chk("final data1", data1, last1);
        chk("valid/frame_err overlap", overlap, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
